// File: rtl/clock_pkg.sv
// Shared types, blink masks and counter-width helpers for the clock time-setting logic.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        CLR_SS = 3'd3
    } state_t;

    // Digit order is seg3..seg0; a set bit blanks that digit during the blink phase.
    localparam logic [3:0] MASK_RUN    = 4'b0000;
    localparam logic [3:0] MASK_SET_HH = 4'b1100;
    localparam logic [3:0] MASK_SET_MM = 4'b0011;
    localparam logic [3:0] MASK_CLR_SS = 4'b0000;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [3:0] blink_mask_of(input state_t s);
        case (s)
            SET_HH:  return MASK_SET_HH;
            SET_MM:  return MASK_SET_MM;
            CLR_SS:  return MASK_CLR_SS;
            default: return MASK_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and datapath control outputs of the time-setting controller.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic       button_sm;
    logic       button_count;
    state_t     state;
    logic       cnt_run;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic [3:0] blink_mask;

    // Master drives the buttons and watches the controls; slave is the controller.
    modport master (
        output button_sm, button_count,
        input  state, cnt_run, inc_hour, inc_min, clr_sec, blink_mask
    );

    modport slave (
        input  button_sm, button_count,
        output state, cnt_run, inc_hour, inc_min, clr_sec, blink_mask
    );

endinterface

// File: rtl/btn_press.sv
// One push button: 2-FF synchronizer, debounce, hold timer and short/long/repeat events.
module btn_press
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 50000,
    parameter int unsigned LONG_PRESS_CYC = 50000000,
    parameter int unsigned REPEAT_CYC     = 12500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,     // raw, active-low, asynchronous
    output logic short_o,    // release before the long threshold
    output logic long_o,     // hold reached the long threshold
    output logic cnt_evt_o   // press, long threshold, then every repeat period
);

    localparam int unsigned DbW   = cnt_width(DEBOUNCE_CYC - 1);
    localparam int unsigned HoldW = cnt_width(LONG_PRESS_CYC);
    localparam int unsigned RepW  = cnt_width(REPEAT_CYC - 1);

    logic [1:0]       sync_q;
    logic             db_q, db_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             armed_q, armed_d;
    logic [DbW-1:0]   arm_cnt_q, arm_cnt_d;
    logic             pressed_q, pressed_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_done_q, long_done_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             cnt_evt_q, cnt_evt_d;
    logic             press, rel_evt, long_hit, rep_hit;

    // Debounce and arming: a press only counts once a released level has been seen, so a
    // button held through reset has to be let go before it can press again.
    always_comb begin
        db_d      = db_q;
        db_cnt_d  = '0;
        armed_d   = armed_q;
        arm_cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
                db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        if (!armed_q && sync_q[1] && db_q) begin
            if (arm_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + 1'b1;
            end
        end
    end

    // Hold timer and event generation from debounced edges.
    always_comb begin
        press    = db_q && !db_d && armed_q;
        rel_evt  = !db_q && db_d;
        long_hit = pressed_q && !long_done_q && (hold_q == HoldW'(LONG_PRESS_CYC - 1));
        rep_hit  = 1'b0;

        pressed_d = pressed_q;
        if (press) begin
            pressed_d = 1'b1;
        end else if (rel_evt) begin
            pressed_d = 1'b0;
        end

        hold_d = hold_q;
        if (press) begin
            hold_d = '0;
        end else if (pressed_q && (hold_q != HoldW'(LONG_PRESS_CYC))) begin
            hold_d = hold_q + 1'b1;
        end

        long_done_d = long_done_q;
        if (press) begin
            long_done_d = 1'b0;
        end else if (long_hit) begin
            long_done_d = 1'b1;
        end

        // The releasing edge still counts as held, so a repeat due on that edge fires.
        rep_d = rep_q;
        if (press || long_hit) begin
            rep_d = '0;
        end else if (pressed_q && long_done_q) begin
            if (rep_q == RepW'(REPEAT_CYC - 1)) begin
                rep_d   = '0;
                rep_hit = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end

        short_d   = rel_evt && pressed_q && (hold_d < HoldW'(LONG_PRESS_CYC));
        long_d    = long_hit;
        cnt_evt_d = press || long_hit || rep_hit;
    end

    // All button state; debounced level resets to released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= 2'b11;
            db_q        <= 1'b1;
            db_cnt_q    <= '0;
            armed_q     <= 1'b0;
            arm_cnt_q   <= '0;
            pressed_q   <= 1'b0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            rep_q       <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            cnt_evt_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_ni};
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            armed_q     <= armed_d;
            arm_cnt_q   <= arm_cnt_d;
            pressed_q   <= pressed_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            rep_q       <= rep_d;
            short_q     <= short_d;
            long_q      <= long_d;
            cnt_evt_q   <= cnt_evt_d;
        end
    end

    assign short_o   = short_q;
    assign long_o    = long_q;
    assign cnt_evt_o = cnt_evt_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: button events drive a mode FSM, action pulses and digit blinking.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 50000,
    parameter int unsigned LONG_PRESS_CYC = 50000000,
    parameter int unsigned REPEAT_CYC     = 12500000,
    parameter int unsigned BLINK_CYC      = 25000000,
    parameter int unsigned TIMEOUT_CYC    = 500000000
) (
    input  logic            clk50m,
    input  logic            rst_n,
    clock_set_ctrl_if.slave ctrl_io
);

    localparam int unsigned ToW = cnt_width(TIMEOUT_CYC - 1);
    localparam int unsigned BlW = cnt_width(BLINK_CYC - 1);

    logic           sm_short, sm_long, cnt_evt;
    logic           unused_sm_cnt, unused_cnt_short, unused_cnt_long;
    state_t         state_q, state_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           to_hit, stay;
    logic           inc_hour_q, inc_hour_d;
    logic           inc_min_q, inc_min_d;
    logic           clr_sec_q, clr_sec_d;
    logic [BlW-1:0] blink_cnt_q, blink_cnt_d;
    logic           phase_q, phase_d;
    logic [3:0]     blink_mask_q, blink_mask_d;

    btn_press #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .LONG_PRESS_CYC(LONG_PRESS_CYC),
        .REPEAT_CYC    (REPEAT_CYC)
    ) u_btn_sm (
        .clk_i    (clk50m),
        .rst_ni   (rst_n),
        .btn_ni   (ctrl_io.button_sm),
        .short_o  (sm_short),
        .long_o   (sm_long),
        .cnt_evt_o(unused_sm_cnt)
    );

    btn_press #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .LONG_PRESS_CYC(LONG_PRESS_CYC),
        .REPEAT_CYC    (REPEAT_CYC)
    ) u_btn_count (
        .clk_i    (clk50m),
        .rst_ni   (rst_n),
        .btn_ni   (ctrl_io.button_count),
        .short_o  (unused_cnt_short),
        .long_o   (unused_cnt_long),
        .cnt_evt_o(cnt_evt)
    );

    // Mode state register.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode: short steps, long or inactivity leave a set state; bad codes recover to RUN.
    always_comb begin
        state_d = state_q;
        to_hit  = (state_q != RUN) && !sm_short && !cnt_evt
                  && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
        case (state_q)
            RUN:    if (sm_short) state_d = SET_HH;
            SET_HH: begin
                if (sm_short) state_d = SET_MM;
                else if (sm_long || to_hit) state_d = RUN;
            end
            SET_MM: begin
                if (sm_short) state_d = CLR_SS;
                else if (sm_long || to_hit) state_d = RUN;
            end
            CLR_SS: begin
                if (sm_short || sm_long || to_hit) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Action pulses, inactivity timer and blink phase; a count event on a mode change is dropped.
    always_comb begin
        stay       = (state_d == state_q);
        inc_hour_d = cnt_evt && stay && (state_q == SET_HH);
        inc_min_d  = cnt_evt && stay && (state_q == SET_MM);
        clr_sec_d  = cnt_evt && stay && (state_q == CLR_SS);

        if ((state_q == RUN) || !stay || sm_short || cnt_evt) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        // Restarting on edits keeps the digit being changed visible.
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (!stay || inc_hour_d || inc_min_d || clr_sec_d) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BlW'(BLINK_CYC - 1)) begin
            blink_cnt_d = '0;
            phase_d     = !phase_q;
        end

        blink_mask_d = phase_d ? blink_mask_of(state_d) : 4'b0000;
    end

    // Registered outputs and timers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q     <= '0;
            inc_hour_q   <= 1'b0;
            inc_min_q    <= 1'b0;
            clr_sec_q    <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            blink_mask_q <= 4'b0000;
        end else begin
            to_cnt_q     <= to_cnt_d;
            inc_hour_q   <= inc_hour_d;
            inc_min_q    <= inc_min_d;
            clr_sec_q    <= clr_sec_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            blink_mask_q <= blink_mask_d;
        end
    end

    assign ctrl_io.state      = state_q;
    assign ctrl_io.cnt_run    = (state_q == RUN);
    assign ctrl_io.inc_hour   = inc_hour_q;
    assign ctrl_io.inc_min    = inc_min_q;
    assign ctrl_io.clr_sec    = clr_sec_q;
    assign ctrl_io.blink_mask = blink_mask_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with shortened timing parameters.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    localparam int unsigned DEB   = 4;
    localparam int unsigned LONG  = 100;
    localparam int unsigned REP   = 20;
    localparam int unsigned BLINK = 10;
    localparam int unsigned TO    = 1000;

    // Pulse kinds as {clr_sec, inc_min, inc_hour}.
    localparam int unsigned K_HOUR = 1;
    localparam int unsigned K_MIN  = 2;
    localparam int unsigned K_CLR  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .DEBOUNCE_CYC  (DEB),
        .LONG_PRESS_CYC(LONG),
        .REPEAT_CYC    (REP),
        .BLINK_CYC     (BLINK),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk50m (clk),
        .rst_n  (rst_n),
        .ctrl_io(bus)
    );

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Every observed pulse must match the next expected pulse kind.
    always @(negedge clk) begin
        if (rst_n && (bus.inc_hour || bus.inc_min || bus.clr_sec)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, bus.clr_sec, bus.inc_min, bus.inc_hour}, 32'd0);
            end else begin
                check("pulse_kind", {29'd0, bus.clr_sec, bus.inc_min, bus.inc_hour},
                      exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds one button low for exactly n cycles, then releases both.
    task automatic hold_btn(input bit sm, input int n);
        @(negedge clk);
        if (sm) bus.button_sm = 1'b0;
        else bus.button_count = 1'b0;
        repeat (n) @(negedge clk);
        bus.button_sm    = 1'b1;
        bus.button_count = 1'b1;
    endtask

    task automatic short_sm();
        hold_btn(1'b1, 30);
        cycles(20);
    endtask

    task automatic count_press();
        hold_btn(1'b0, 30);
        cycles(20);
    endtask

    task automatic wait_state(input string tag, input state_t exp, input int budget,
                              output int waited);
        waited = 0;
        while ((bus.state !== exp) && (waited < budget)) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 32'(bus.state), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'(RUN));
        check({tag, "_cnt_run"}, 32'(bus.cnt_run), 32'd1);
        check({tag, "_pulses"}, {29'd0, bus.clr_sec, bus.inc_min, bus.inc_hour}, 32'd0);
        check({tag, "_blink"}, 32'(bus.blink_mask), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.button_sm    = 1'b1;
        bus.button_count = 1'b1;
        rst_n            = 1'b0;
        cycles(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cycles(10);

        // Glitches shorter than the debounce window are ignored.
        for (int i = 0; i < 3; i++) begin
            hold_btn(1'b1, 3);
            cycles(5);
        end
        cycles(20);
        check("glitch_state", 32'(bus.state), 32'(RUN));
        check("glitch_cnt_run", 32'(bus.cnt_run), 32'd1);

        // Short press enters SET_HH; hour digits blink with a 10-cycle half-period.
        hold_btn(1'b1, 30);
        wait_state("enter_hh", SET_HH, 20, w);
        check("hh_cnt_run", 32'(bus.cnt_run), 32'd0);
        for (int i = 0; i < 40; i++) begin
            check("blink_hh", 32'(bus.blink_mask), ((i / 10) % 2 == 1) ? 32'hC : 32'h0);
            @(negedge clk);
        end

        // Single count press, then a 160-cycle hold: press, long, three repeats.
        exp_q.push_back(K_HOUR);
        count_press();
        check("single_hour_drained", exp_q.size(), 32'd0);
        repeat (5) exp_q.push_back(K_HOUR);
        hold_btn(1'b0, 160);
        cycles(20);
        check("repeat_hour_drained", exp_q.size(), 32'd0);
        check("still_hh", 32'(bus.state), 32'(SET_HH));

        // Step through the set states with an action in each.
        short_sm();
        check("enter_mm", 32'(bus.state), 32'(SET_MM));
        exp_q.push_back(K_MIN);
        count_press();
        check("min_drained", exp_q.size(), 32'd0);
        short_sm();
        check("enter_ss", 32'(bus.state), 32'(CLR_SS));
        check("ss_blink", 32'(bus.blink_mask), 32'd0);
        exp_q.push_back(K_CLR);
        count_press();
        check("clr_drained", exp_q.size(), 32'd0);
        short_sm();
        check("back_to_run", 32'(bus.state), 32'(RUN));
        check("run_cnt_run", 32'(bus.cnt_run), 32'd1);
        count_press();
        check("run_no_pulse", exp_q.size(), 32'd0);
        check("run_blink", 32'(bus.blink_mask), 32'd0);

        // Long press in SET_MM returns to RUN at the threshold, no step on release.
        short_sm();
        short_sm();
        check("long_setup", 32'(bus.state), 32'(SET_MM));
        bus.button_sm = 1'b0;
        wait_state("long_to_run", RUN, 140, w);
        check("long_not_early", 32'(w >= int'(LONG)), 32'd1);
        cycles(150 - w);
        bus.button_sm = 1'b1;
        cycles(20);
        check("long_release_run", 32'(bus.state), 32'(RUN));

        // Inactivity timeout in SET_HH.
        short_sm();
        check("timeout_setup", 32'(bus.state), 32'(SET_HH));
        cycles(900);
        check("timeout_not_early", 32'(bus.state), 32'(SET_HH));
        wait_state("timeout_run", RUN, 200, w);

        // Reset mid-hold; the still-held button must not count as a new press.
        short_sm();
        short_sm();
        check("rst_setup", 32'(bus.state), 32'(SET_MM));
        bus.button_sm = 1'b0;
        cycles(50);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        cycles(3);
        rst_n = 1'b1;
        cycles(50);
        bus.button_sm = 1'b1;
        cycles(30);
        check("held_through_reset", 32'(bus.state), 32'(RUN));
        short_sm();
        check("press_after_reset", 32'(bus.state), 32'(SET_HH));

        cycles(10);
        check("final_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the digital clock. It debounces the two raw push buttons (button_sm, button_count) and classifies each press as short or long. A mode FSM then sequences the clock datapath: it stops/runs the time counter, issues increment/clear pulses to hours, minutes and seconds, and drives per-digit blink enables for the seg3..seg0 display path.

Parameters:
DEBOUNCE_CYC, 50000, consecutive stable cycles before the debounced level updates (1 ms at 50 MHz)
LONG_PRESS_CYC, 50000000, hold time in cycles that makes a press "long" (1 s)
REPEAT_CYC, 12500000, auto-repeat period for a held button_count after a long press (250 ms)
BLINK_CYC, 25000000, half-period of the blink phase (0.5 s)
TIMEOUT_CYC, 500000000, inactivity in a set state before returning to RUN (10 s)

Ports:
clk50m  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
button_sm  in  1  raw mode button, active-low, asynchronous to clk50m
button_count  in  1  raw count button, active-low, asynchronous to clk50m
state  out  3  current mode, encoded as a clock_pkg::state_t value
cnt_run  out  1  enables the seconds counter; high only in RUN
inc_hour  out  1  one-cycle pulse: hour +1 (modulo 24 in the datapath)
inc_min  out  1  one-cycle pulse: minute +1 (modulo 60 in the datapath)
clr_sec  out  1  one-cycle pulse: seconds := 0
blink_mask  out  4  per-digit blank enable for seg3..seg0; 1 = blank this digit

Behaviour:
- Reset (async assert, sync release):
  - state=RUN, cnt_run=1, all pulses 0, blink_mask=0.
  - Debounced levels =1 (released). All counters =0.
- Input path per button:
  - 2-FF synchronizer, then debounce counter.
  - The debounced level changes only after DEBOUNCE_CYC consecutive cycles of the new synchronized level. Any glitch restarts the count.
  - Raw edge to debounced edge latency: 2 + DEBOUNCE_CYC cycles.
  - A press is a debounced 1->0 transition. The hold counter runs while the debounced level is 0 and saturates.
- Press classification:
  - short_sm: one-cycle event on release, only if hold < LONG_PRESS_CYC.
  - long_sm: one-cycle event when hold reaches LONG_PRESS_CYC; nothing further on release.
  - cnt_evt: one event on press. Then, while still held, one event at hold = LONG_PRESS_CYC and every REPEAT_CYC after that.
- Mode FSM, states RUN=0, SET_HH=1, SET_MM=2, CLR_SS=3 (codes 4..7 unused and recover to RUN):
  - short_sm steps RUN -> SET_HH -> SET_MM -> CLR_SS -> RUN.
  - long_sm in any set state -> RUN. long_sm in RUN is ignored.
  - Inactivity: if TIMEOUT_CYC cycles pass with no short_sm or cnt_evt in a set state -> RUN.
- Action pulses on cnt_evt, registered, 1 cycle after the event:
  - SET_HH -> inc_hour. SET_MM -> inc_min. CLR_SS -> clr_sec.
  - RUN: cnt_evt is ignored.
- Simultaneous events: an sm event has priority. A cnt_evt in the same cycle as a state change is dropped.
- cnt_run = (state==RUN). It drops in the same cycle state leaves RUN.
- Blink:
  - The phase counter toggles the blink phase every BLINK_CYC cycles.
  - Phase and counter reset to 0 on every state change and on every action pulse, so the edited digits stay visible while editing.
  - blink_mask = phase ? mask : 0, where mask is SET_HH 1100, SET_MM 0011, CLR_SS 0000, RUN 0000.
- Reset mid-press: everything returns to reset values. A button still held after reset must first be released (debounced) before it can produce a new press.
- All outputs are registered (state, pulses, blink_mask). cnt_run is decoded from the state register only.

Decomposition:
- clock_pkg:
  - state_t enum, 3 bits: RUN, SET_HH, SET_MM, CLR_SS.
  - Blink mask constants per state.
  - Shared clog2-based width helpers for the counters.
- Sub-module btn_press: synchronizer + debounce + hold counter + short/long/repeat event generation.
  - Parameters: DEBOUNCE_CYC, LONG_PRESS_CYC, REPEAT_CYC.
  - Instantiated twice. Only the needed outputs are used per button.

Test Plan (bench overrides DEBOUNCE_CYC=4, LONG_PRESS_CYC=100, REPEAT_CYC=20, BLINK_CYC=10, TIMEOUT_CYC=1000):
1. Reset, then 3 cycles low pulses on button_sm -> debounce rejects them; state stays 0, cnt_run=1, no pulses.
2. button_sm low 30 cycles then release -> state=1 about 7 cycles after release, cnt_run=0. blink_mask alternates 0000/1100 every 10 cycles.
3. In state 1, button_count low 30 cycles -> exactly one inc_hour. Hold 160 cycles -> 1 + 1 + 3 = 5 inc_hour pulses (press, long at 100, repeats at 120/140/160).
4. Three short button_sm presses from state 1 -> states 2 then 3 then 0. A button_count press in state 3 -> one clr_sec. In state 0 a button_count press -> no pulse.
5. In state 2, button_sm held 150 cycles -> state=0 when hold reaches 100, with no step to 3 on release. Separately, idle 1000 cycles in state 1 -> state=0.
6. Assert rst_n=0 mid-hold in state 2 -> immediate state=0 and all outputs reset. A still-held button produces no event until it is released and pressed again.
